// File: rtl/datagram_pkg.sv
// Shared game datagram definitions: field sizes, scene codes, alien record
// layout, total datagram width and the CRC-8 step used by the transmitter.
package datagram_pkg;

  localparam int STATE_SIZE  = 3;
  localparam int LEVEL_SIZE  = 4;
  localparam int SCORE_SIZE  = 16;
  localparam int STRING_SIZE = 16;
  localparam int OBJ_LIMIT   = 4;

  localparam logic [STATE_SIZE-1:0] SCENE_TITLE      = 3'd0;
  localparam logic [STATE_SIZE-1:0] SCENE_INGAME     = 3'd1;
  localparam logic [STATE_SIZE-1:0] SCENE_SCOREBOARD = 3'd2;
  localparam logic [STATE_SIZE-1:0] SCENE_GAMEOVER   = 3'd3;

  // In-game body: level, score, then frame data (laser header + aliens)
  localparam int ALIEN_BITS       = 35;
  localparam int FRAME_HDR_BITS   = 7;
  localparam int FRAME_DATA_SIZE  = FRAME_HDR_BITS + ALIEN_BITS * OBJ_LIMIT;
  localparam int INGAME_BODY_SIZE = LEVEL_SIZE + SCORE_SIZE + FRAME_DATA_SIZE;

  // Scoreboard body: state, input_pos, player score/name, 5 record entries
  localparam int SCORE_ENTRIES        = 5;
  localparam int SCOREBOARD_DATA_SIZE = 1 + 2 + SCORE_SIZE + STRING_SIZE +
                                        SCORE_ENTRIES * (SCORE_SIZE + STRING_SIZE);

  localparam int BODY_SIZE = (INGAME_BODY_SIZE > SCOREBOARD_DATA_SIZE) ?
                             INGAME_BODY_SIZE : SCOREBOARD_DATA_SIZE;
  localparam int MESSAGE_SIZE = STATE_SIZE + BODY_SIZE;

  localparam logic [7:0] TX_PREAMBLE = 8'hA5;

  typedef struct packed {
    logic       active;
    logic [1:0] type_id;
    logic [1:0] frame_num;
    logic [3:0] r;
    logic [1:0] quadrant;
    logic [9:0] x_pos;
    logic [9:0] y_pos;
    logic [1:0] deriv_left;
    logic [1:0] deriv_right;
  } AlienData;

  // Alien record as the display side unpacks it: active in the LSB,
  // deriv_right in the MSBs.
  function automatic logic [ALIEN_BITS-1:0] alien_bits(input AlienData a);
    return {a.deriv_right, a.deriv_left, a.y_pos, a.x_pos,
            a.quadrant, a.r, a.frame_num, a.type_id, a.active};
  endfunction

  // One bit of CRC-8, polynomial 0x07
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[7] ^ din;
    return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

endpackage

// File: rtl/datagram_tx_if.sv
// Field and status bundle between the game logic and the datagram transmitter.
interface datagram_tx_if;
  import datagram_pkg::*;

  logic                           send_req;
  logic [STATE_SIZE-1:0]          core_state;
  logic [LEVEL_SIZE-1:0]          level;
  logic [SCORE_SIZE-1:0]          score;
  logic                           laser_active;
  logic [3:0]                     laser_r;
  logic [1:0]                     laser_quadrant;
  AlienData                       obj_data [0:OBJ_LIMIT-1];
  logic                           scoreboard_state;
  logic [1:0]                     input_pos;
  logic [SCORE_SIZE-1:0]          player_score;
  logic [STRING_SIZE-1:0]         player_name;
  logic [SCORE_SIZE*5-1:0]        score_rec;
  logic [STRING_SIZE*5-1:0]       name_rec;
  logic                           tx_line;
  logic                           busy;
  logic                           frame_done;
  logic                           overrun;

  modport master (
    output send_req, core_state, level, score, laser_active, laser_r,
           laser_quadrant, obj_data, scoreboard_state, input_pos,
           player_score, player_name, score_rec, name_rec,
    input  tx_line, busy, frame_done, overrun
  );

  modport slave (
    input  send_req, core_state, level, score, laser_active, laser_r,
           laser_quadrant, obj_data, scoreboard_state, input_pos,
           player_score, player_name, score_rec, name_rec,
    output tx_line, busy, frame_done, overrun
  );
endinterface

// File: rtl/datagram_packer.sv
// Combinational mapping of game fields into the datagram bit layout
// consumed by the quadrant display boards. Datagram = {body, core_state}.
module datagram_packer
  import datagram_pkg::*;
(
  input  logic [STATE_SIZE-1:0]     core_state,
  input  logic [LEVEL_SIZE-1:0]     level,
  input  logic [SCORE_SIZE-1:0]     score,
  input  logic                      laser_active,
  input  logic [3:0]                laser_r,
  input  logic [1:0]                laser_quadrant,
  input  AlienData                  obj_data [0:OBJ_LIMIT-1],
  input  logic                      scoreboard_state,
  input  logic [1:0]                input_pos,
  input  logic [SCORE_SIZE-1:0]     player_score,
  input  logic [STRING_SIZE-1:0]    player_name,
  input  logic [SCORE_SIZE*5-1:0]   score_rec,
  input  logic [STRING_SIZE*5-1:0]  name_rec,
  output logic [MESSAGE_SIZE-1:0]   datagram
);

  localparam int FRAME_BASE = LEVEL_SIZE + SCORE_SIZE;
  localparam int OBJ_BASE   = FRAME_BASE + FRAME_HDR_BITS;
  localparam int SB_PSCORE  = 3;
  localparam int SB_PNAME   = SB_PSCORE + SCORE_SIZE;
  localparam int SB_REC     = SB_PNAME + STRING_SIZE;
  localparam int SB_ENTRY   = SCORE_SIZE + STRING_SIZE;

  logic [BODY_SIZE-1:0] ingame_body;
  logic [BODY_SIZE-1:0] sb_body;

  // In-game body: level, score, laser header, then one record per alien
  always_comb begin
    ingame_body = '0;
    ingame_body[LEVEL_SIZE-1:0]            = level;
    ingame_body[LEVEL_SIZE +: SCORE_SIZE]  = score;
    ingame_body[FRAME_BASE]                = laser_active;
    ingame_body[FRAME_BASE+1 +: 4]         = laser_r;
    ingame_body[FRAME_BASE+5 +: 2]         = laser_quadrant;
    for (int unsigned k = 0; k < OBJ_LIMIT; k++) begin
      ingame_body[OBJ_BASE + k*ALIEN_BITS +: ALIEN_BITS] = alien_bits(obj_data[k]);
    end
  end

  // Scoreboard body: cursor state, player entry, then score/name pairs 0..4
  always_comb begin
    sb_body = '0;
    sb_body[0]                          = scoreboard_state;
    sb_body[1 +: 2]                     = input_pos;
    sb_body[SB_PSCORE +: SCORE_SIZE]    = player_score;
    sb_body[SB_PNAME +: STRING_SIZE]    = player_name;
    for (int unsigned k = 0; k < SCORE_ENTRIES; k++) begin
      sb_body[SB_REC + k*SB_ENTRY +: SCORE_SIZE] =
        score_rec[k*SCORE_SIZE +: SCORE_SIZE];
      sb_body[SB_REC + k*SB_ENTRY + SCORE_SIZE +: STRING_SIZE] =
        name_rec[k*STRING_SIZE +: STRING_SIZE];
    end
  end

  // Scene code selects which body travels with it
  always_comb begin
    datagram = {(core_state == SCENE_SCOREBOARD) ? sb_body : ingame_body, core_state};
  end

endmodule

// File: rtl/datagram_tx.sv
// Serial datagram transmitter: snapshots the packed datagram when a frame
// starts and sends preamble (LSB first), payload (LSB first), optional CRC-8
// (MSB first) and an idle-high gap on one line.
// Optional feature macro: DATAGRAM_CRC_EN inserts the CRC after the payload.
module datagram_tx
  import datagram_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 4,
  parameter int         GAP_BITS     = 16,
  parameter logic [7:0] PREAMBLE     = TX_PREAMBLE
) (
  input  logic          clk,
  input  logic          rst,
  datagram_tx_if.slave  bus
);

  localparam int BAUD_W  = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_MAX = (MESSAGE_SIZE > GAP_BITS) ? MESSAGE_SIZE : GAP_BITS;
  localparam int BIT_W   = $clog2(BIT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_PAYLOAD,
`ifdef DATAGRAM_CRC_EN
    S_CRC,
`endif
    S_GAP
  } state_t;

  state_t                  state;
  logic [BAUD_W-1:0]       baud_cnt;
  logic [BIT_W-1:0]        bit_cnt;
  logic [MESSAGE_SIZE-1:0] shreg;
  logic [7:0]              pre_sh;
  logic                    pending;
  logic [MESSAGE_SIZE-1:0] packed_dg;
  logic                    baud_end;
  logic                    last_gap;
  logic                    start;
`ifdef DATAGRAM_CRC_EN
  logic [7:0]              crc;
  logic [7:0]              crc_next;
`endif

  datagram_packer u_packer (
    .core_state       (bus.core_state),
    .level            (bus.level),
    .score            (bus.score),
    .laser_active     (bus.laser_active),
    .laser_r          (bus.laser_r),
    .laser_quadrant   (bus.laser_quadrant),
    .obj_data         (bus.obj_data),
    .scoreboard_state (bus.scoreboard_state),
    .input_pos        (bus.input_pos),
    .player_score     (bus.player_score),
    .player_name      (bus.player_name),
    .score_rec        (bus.score_rec),
    .name_rec         (bus.name_rec),
    .datagram         (packed_dg)
  );

  // Bit timing and frame-start decode
  always_comb begin
    baud_end = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
    last_gap = (state == S_GAP) && baud_end && (bit_cnt == BIT_W'(GAP_BITS - 1));
    start    = ((state == S_IDLE) || last_gap) && (bus.send_req || pending);
  end

`ifdef DATAGRAM_CRC_EN
  // CRC value after absorbing the payload bit currently on the line
  always_comb begin
    crc_next = crc8_step(crc, shreg[0]);
  end
`endif

  // Frame sequencer with registered line, busy, done and overrun outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      baud_cnt       <= '0;
      bit_cnt        <= '0;
      shreg          <= '0;
      pre_sh         <= '0;
      pending        <= 1'b0;
`ifdef DATAGRAM_CRC_EN
      crc            <= '0;
`endif
      bus.tx_line    <= 1'b1;
      bus.busy       <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.overrun    <= 1'b0;
    end else begin
      bus.frame_done <= 1'b0;

      if (state != S_IDLE) begin
        baud_cnt <= baud_end ? '0 : baud_cnt + 1'b1;
      end

      if ((state != S_IDLE) && !last_gap && bus.send_req) begin
        if (pending) bus.overrun <= 1'b1;
        else         pending     <= 1'b1;
      end

      case (state)
        S_PREAMBLE: if (baud_end) begin
          if (bit_cnt == BIT_W'(7)) begin
            state       <= S_PAYLOAD;
            bit_cnt     <= '0;
            bus.tx_line <= shreg[0];
          end else begin
            bit_cnt     <= bit_cnt + 1'b1;
            bus.tx_line <= pre_sh[1];
            pre_sh      <= pre_sh >> 1;
          end
        end

        S_PAYLOAD: if (baud_end) begin
          shreg <= shreg >> 1;
`ifdef DATAGRAM_CRC_EN
          crc   <= crc_next;
`endif
          if (bit_cnt == BIT_W'(MESSAGE_SIZE - 1)) begin
            bit_cnt <= '0;
`ifdef DATAGRAM_CRC_EN
            state       <= S_CRC;
            bus.tx_line <= crc_next[7];
`else
            state       <= S_GAP;
            bus.tx_line <= 1'b1;
`endif
          end else begin
            bit_cnt     <= bit_cnt + 1'b1;
            bus.tx_line <= shreg[1];
          end
        end

`ifdef DATAGRAM_CRC_EN
        S_CRC: if (baud_end) begin
          crc <= crc << 1;
          if (bit_cnt == BIT_W'(7)) begin
            state       <= S_GAP;
            bit_cnt     <= '0;
            bus.tx_line <= 1'b1;
          end else begin
            bit_cnt     <= bit_cnt + 1'b1;
            bus.tx_line <= crc[6];
          end
        end
`endif

        S_GAP: if (baud_end) begin
          if (bit_cnt == BIT_W'(GAP_BITS - 1)) begin
            bus.frame_done <= 1'b1;
            state          <= S_IDLE;
            bus.busy       <= 1'b0;
            bit_cnt        <= '0;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        default: ;
      endcase

      // A start overrides the gap-end return to IDLE so a pending frame
      // follows back to back; a request landing on the last gap cycle while
      // another is already pending stays queued for the frame after.
      if (start) begin
        state       <= S_PREAMBLE;
        baud_cnt    <= '0;
        bit_cnt     <= '0;
        shreg       <= packed_dg;
        pre_sh      <= PREAMBLE;
        pending     <= last_gap && pending && bus.send_req;
`ifdef DATAGRAM_CRC_EN
        crc         <= '0;
`endif
        bus.busy    <= 1'b1;
        bus.tx_line <= PREAMBLE[0];
      end
    end
  end

endmodule
